// File: rtl/instr_fetch_stage.sv
// Single-entry instruction fetch stage: PC register, combinational imem lookup, registered output with redirect squash.
// Optional retired-instruction counter enabled by defining FETCH_STAT_EN.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_dword,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [0:0] {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic        if_valid_reg;
  logic [31:0] if_pc_reg;
  logic [31:0] if_instr_reg;
  logic        load;
  logic        squash;
  logic        retire;

  // Masking keeps the PC word aligned regardless of the target's low bits.
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Redirect wins over both load and stall; nothing happens in BOOT.
  always_comb begin
    squash = 1'b0;
    load   = 1'b0;
    retire = 1'b0;
    if (state_reg == RUN) begin
      squash = redirect_valid;
      load   = (!if_valid_reg || if_ready) && !redirect_valid;
      retire = if_valid_reg && if_ready && !redirect_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC & ALIGN_MASK;
      if_valid_reg <= 1'b0;
      if_pc_reg    <= 32'h0;
      if_instr_reg <= 32'h0;
    end else if (squash) begin
      pc_reg       <= redirect_pc & ALIGN_MASK;
      if_valid_reg <= 1'b0;
    end else if (load) begin
      pc_reg       <= pc_reg + 32'd4;
      if_valid_reg <= 1'b1;
      if_pc_reg    <= pc_reg;
      if_instr_reg <= imem_dword;
    end
  end

`ifdef FETCH_STAT_EN
  logic [31:0] fetch_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_reg <= 32'h0;
    end else if (retire) begin
      fetch_count_reg <= fetch_count_reg + 32'd1;
    end
  end

  assign fetch_count = fetch_count_reg;
`else
  logic retire_unused;
  assign retire_unused = retire;
`endif

  assign imem_addr = pc_reg[31:2];
  assign if_valid  = if_valid_reg;
  assign if_pc     = if_pc_reg;
  assign if_instr  = if_instr_reg;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed testbench for instr_fetch_stage; checks reset, stall, redirect, alignment, wrap and the optional counter.
module tb_instr_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [29:0] imem_addr;
  logic [31:0] imem_dword;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_STAT_EN
  logic [31:0] fetch_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word content derived from its byte address.
  assign imem_dword = {imem_addr, 2'b00} ^ KEY;

  instr_fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_dword(imem_dword),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr)
`ifdef FETCH_STAT_EN
    , .fetch_count(fetch_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
    $display("[TB] t=%0t rst=%0b rv=%0b rdy=%0b addr=%h v=%0b pc=%h instr=%h",
             $time, rst, redirect_valid, if_ready, imem_addr, if_valid, if_pc, if_instr);
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
    step(); step();
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", if_valid); end
    tests++; if (if_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", if_pc); end
    tests++; if (if_instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h exp 0", if_instr); end
    tests++; if (imem_addr !== 30'h40) begin fails++; $display("FAIL reset_addr got %h exp 40", imem_addr); end
    rst = 1'b0;
    step();
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL boot_valid got %0b exp 0", if_valid); end
    tests++; if (imem_addr !== 30'h40) begin fails++; $display("FAIL boot_addr got %h exp 40", imem_addr); end
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin fails++; $display("FAIL first_fetch got v=%0b pc=%h exp v=1 pc=100", if_valid, if_pc); end
    tests++; if (if_instr !== (32'h100 ^ KEY)) begin fails++; $display("FAIL first_instr got %h exp %h", if_instr, 32'h100 ^ KEY); end
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h104) begin fails++; $display("FAIL b2b_104 got v=%0b pc=%h exp v=1 pc=104", if_valid, if_pc); end
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h108) begin fails++; $display("FAIL b2b_108 got v=%0b pc=%h exp v=1 pc=108", if_valid, if_pc); end
    tests++; if (if_instr !== (32'h108 ^ KEY)) begin fails++; $display("FAIL b2b_instr got %h exp %h", if_instr, 32'h108 ^ KEY); end
  endtask

  task automatic test_stall();
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step();
    tests++; if (if_valid !== 1'b0 || imem_addr !== 30'h2) begin fails++; $display("FAIL stall_setup got v=%0b addr=%h exp v=0 addr=2", if_valid, imem_addr); end
    redirect_valid = 1'b0; if_ready = 1'b0;
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin fails++; $display("FAIL stall_load got v=%0b pc=%h exp v=1 pc=8", if_valid, if_pc); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== (32'h8 ^ KEY) || imem_addr !== 30'h3) begin
        fails++;
        $display("FAIL stall_hold%0d got v=%0b pc=%h instr=%h addr=%h exp v=1 pc=8 instr=%h addr=3",
                 i, if_valid, if_pc, if_instr, imem_addr, 32'h8 ^ KEY);
      end
    end
    if_ready = 1'b1;
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'hC) begin fails++; $display("FAIL stall_release got v=%0b pc=%h exp v=1 pc=c", if_valid, if_pc); end
  endtask

  task automatic test_redirect();
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h2000;
    step();
    tests++; if (if_valid !== 1'b0 || imem_addr !== 30'h800) begin fails++; $display("FAIL redir_squash got v=%0b addr=%h exp v=0 addr=800", if_valid, imem_addr); end
    redirect_valid = 1'b0;
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h2000) begin fails++; $display("FAIL redir_target got v=%0b pc=%h exp v=1 pc=2000", if_valid, if_pc); end
    tests++; if (if_instr !== (32'h2000 ^ KEY)) begin fails++; $display("FAIL redir_instr got %h exp %h", if_instr, 32'h2000 ^ KEY); end
    if_ready = 1'b1;
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h1003;
    step();
    tests++; if (if_valid !== 1'b0 || imem_addr !== 30'h400) begin fails++; $display("FAIL misalign_pc got v=%0b addr=%h exp v=0 addr=400", if_valid, imem_addr); end
    redirect_valid = 1'b0;
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h1000) begin fails++; $display("FAIL misalign_fetch got v=%0b pc=%h exp v=1 pc=1000", if_valid, if_pc); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; if_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top got v=%0b pc=%h exp v=1 pc=fffffffc", if_valid, if_pc); end
    tests++; if (imem_addr !== 30'h0) begin fails++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin fails++; $display("FAIL wrap_zero got v=%0b pc=%h exp v=1 pc=0", if_valid, if_pc); end
  endtask

  task automatic test_reset_override();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3000;
    step();
    tests++; if (if_valid !== 1'b0 || imem_addr !== 30'h40 || if_pc !== 32'h0) begin fails++; $display("FAIL rst_override got v=%0b addr=%h pc=%h exp v=0 addr=40 pc=0", if_valid, imem_addr, if_pc); end
    rst = 1'b0; redirect_valid = 1'b1;
    step();
    tests++; if (imem_addr !== 30'h40) begin fails++; $display("FAIL boot_ignores_redirect got addr=%h exp 40", imem_addr); end
    redirect_valid = 1'b0;
  endtask

`ifdef FETCH_STAT_EN
  task automatic test_fetch_count();
    rst = 1'b1; redirect_valid = 1'b0; if_ready = 1'b1;
    step();
    tests++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL cnt_reset got %0d exp 0", fetch_count); end
    rst = 1'b0;
    step(); step();
    tests++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL cnt_first_load got %0d exp 0", fetch_count); end
    for (int i = 0; i < 5; i++) step();
    tests++; if (fetch_count !== 32'd5) begin fails++; $display("FAIL cnt_five got %0d exp 5", fetch_count); end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) step();
    tests++; if (fetch_count !== 32'd10) begin fails++; $display("FAIL cnt_ten got %0d exp 10", fetch_count); end
    rst = 1'b1;
    step();
    tests++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL cnt_midreset got %0d exp 0", fetch_count); end
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
    test_reset();
    test_stall();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_reset_override();
`ifdef FETCH_STAT_EN
    test_fetch_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port redirect_valid  input  1  branch/jump redirect request from downstream.
REQ-005 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-006 SHALL have port imem_addr  output  30  word address to the combinational instruction memory.
REQ-007 SHALL have port imem_dword  input  32  instruction word returned by memory in the same cycle.
REQ-008 SHALL have port if_valid  output  1  if_pc/if_instr hold a valid fetched instruction.
REQ-009 SHALL have port if_ready  input  1  decode accepts the current output this cycle.
REQ-010 SHALL have port if_pc  output  32  byte address of the instruction in if_instr.
REQ-011 SHALL have port if_instr  output  32  registered instruction word.

Function
REQ-012 SHALL hold an internal 32-bit pc register with bits [1:0] always 2'b00.
REQ-013 SHALL drive imem_addr = pc[31:2] combinationally in every cycle.
REQ-014 SHALL implement FSM states BOOT and RUN; BOOT entered on reset, RUN entered unconditionally on the next cycle.
REQ-015 SHALL, in BOOT, keep if_valid=0 and not advance pc.
REQ-016 SHALL define "load" in RUN as (!if_valid || if_ready) && !redirect_valid.
REQ-017 SHALL, on load, register if_instr<=imem_dword, if_pc<=pc, if_valid<=1, and set pc<=pc+4.
REQ-018 SHALL, in RUN with if_valid=1 and if_ready=0 and no redirect, hold pc, if_pc, if_instr and if_valid unchanged.
REQ-019 SHALL, when if_valid=1 and if_ready=1 and no redirect, both retire the held instruction and load the next one in the same cycle, giving zero-bubble throughput.
REQ-020 SHALL, on redirect_valid=1 in RUN, set pc<={redirect_pc[31:2],2'b00} and if_valid<=0, discarding the held instruction, regardless of if_ready.
REQ-021 SHALL ignore redirect_valid in BOOT.
REQ-022 SHALL make redirect_valid take priority over load and over stall in the same cycle.
REQ-023 SHALL deliver the first instruction at the redirect target with if_valid=1 exactly two cycles after the redirect edge: one squash cycle, then a load.
REQ-024 SHALL wrap pc modulo 2^32: 32'hFFFF_FFFC+4 gives 32'h0000_0000 with no flag.
REQ-025 SHALL keep imem_dword a purely combinational dependency; no registered output depends on imem_dword except through load.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set pc<=RESET_PC with bits [1:0] forced to 0, if_valid<=0, if_pc<=0, if_instr<=0, state<=BOOT.
REQ-027 SHALL let reset asserted mid-operation override redirect and load in that cycle.
REQ-028 SHALL produce the first if_valid=1, with if_pc=RESET_PC, on the second clock edge after rst deasserts: BOOT, then load.

Configuration
REQ-029 SHALL, when macro FETCH_STAT_EN is defined, add port fetch_count  output  32, a counter of retired instructions.
REQ-030 SHALL increment fetch_count on each cycle with if_valid && if_ready && !redirect_valid, wrap from 32'hFFFF_FFFF to 0, and clear it on rst.
REQ-031 SHALL, without FETCH_STAT_EN, omit the fetch_count port and its logic entirely, with all other behaviour identical.

Verification
REQ-032 SHALL cover reset with RESET_PC=32'h0000_0100 and if_ready=1: imem_addr=30'h40; the first if_valid has if_pc=0x100; subsequent if_pc values are 0x104 and 0x108 on consecutive cycles.
REQ-033 SHALL cover a stall: if_ready=0 for 3 cycles while if_valid=1 with if_pc=0x8: if_pc and if_instr stay constant and imem_addr stays at 30'h3; on release, the next if_pc is 0xC.
REQ-034 SHALL cover a redirect to 0x2000 while if_valid=1 and if_ready=0: the next cycle shows if_valid=0 and imem_addr=30'h800; the following cycle shows if_valid=1 and if_pc=0x2000.
REQ-035 SHALL cover a misaligned redirect_pc=0x1003: pc becomes 0x1000, and the next if_pc is 0x1000.
REQ-036 SHALL cover wrap-around: a redirect to 0xFFFF_FFFC with if_ready=1 produces if_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-037 SHALL cover, with FETCH_STAT_EN defined, 10 retirements with one redirect cycle interleaved: fetch_count=10; reset mid-stream returns fetch_count to 0.
